// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding used by both transmitter and receiver,
// plus the idle line level.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one-word holding register feeding a start/data/parity/stop shifter
// driven by the shared oversampling tick. txd comes straight from a flop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned D_W        = 8,
  parameter int unsigned B_TICK     = 16,
  parameter int unsigned STOP_TICKS = 16,
  parameter int unsigned PAR_EN     = 0,
  parameter int unsigned PAR_ODD    = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic [D_W-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           txd,
  output logic           tx_busy,
  output logic           tx_done
);

  localparam int unsigned MaxTicks = (B_TICK > STOP_TICKS) ? B_TICK : STOP_TICKS;
  localparam int unsigned TW       = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
  localparam int unsigned BW       = (D_W > 1) ? $clog2(D_W) : 1;

  localparam logic [TW-1:0] BitLast  = TW'(B_TICK - 1);
  localparam logic [TW-1:0] StopLast = TW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] DataLast = BW'(D_W - 1);
  localparam logic          ParEn    = (PAR_EN != 0);
  localparam logic          ParOdd   = (PAR_ODD != 0);

  uart_state_e    state_q, state_d;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [D_W-1:0] shift_q, shift_d;
  logic           par_q, par_d;
  logic [D_W-1:0] hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic           txd_q, txd_d;
  logic           done_q, done_d;
  logic           accept;

  assign accept = in_valid & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        // Loading is not tick-aligned: the start bit begins on the very next clock.
        if (hold_full_q) begin
          shift_d     = hold_q;
          par_d       = (^hold_q) ^ ParOdd;
          tick_cnt_d  = '0;
          bit_cnt_d   = '0;
          hold_full_d = 1'b0;
          state_d     = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          if (tick_cnt_q == BitLast) begin
            tick_cnt_d = '0;
            state_d    = StData;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (tick_cnt_q == BitLast) begin
            tick_cnt_d = '0;
            shift_d    = shift_q >> 1;
            if (bit_cnt_q == DataLast) begin
              bit_cnt_d = '0;
              state_d   = ParEn ? StParity : StStop;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          if (tick_cnt_q == BitLast) begin
            tick_cnt_d = '0;
            state_d    = StStop;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (tick_cnt_q == StopLast) begin
            tick_cnt_d = '0;
            done_d     = 1'b1;
            state_d    = StIdle;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A word accepted in the load cycle refills the holding register.
    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    // Line level is registered from the next state so txd changes with the state flop.
    case (state_d)
      StStart:  txd_d = ~IDLE_LEVEL;
      StData:   txd_d = shift_d[0];
      StParity: txd_d = par_d;
      default:  txd_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      txd_q       <= IDLE_LEVEL;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      txd_q       <= txd_d;
      done_q      <= done_d;
    end
  end

  assign in_ready = ~hold_full_q;
  assign txd      = txd_q;
  assign tx_busy  = (state_q != StIdle) | hold_full_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level model (tick count into the frame -> line level) checked
// every cycle on three configurations, plus literal waveform and tick-count expectations.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] in_data0 = 8'h00;
  logic [7:0] in_data_p = 8'h00;
  logic       in_valid0 = 1'b0;
  logic       in_valid_p = 1'b0;
  logic [2:0] txd_w, rdy_w, busy_w, done_w;

  int checks = 0;
  int errors = 0;
  int div = 4;
  int bit_clks = 64;
  int tick_c = 0;
  int tick_total = 0;
  bit chk_en = 1'b0;
  bit dec_en = 1'b1;
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx[6] = '{8'hA5, 8'h55, 8'h0F, 8'h11, 8'h22, 8'h33};

  uart_tx #(.D_W(8), .B_TICK(16), .STOP_TICKS(16), .PAR_EN(0), .PAR_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(rdy_w[0]), .txd(txd_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );
  uart_tx #(.D_W(8), .B_TICK(16), .STOP_TICKS(16), .PAR_EN(1), .PAR_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .in_data(in_data_p), .in_valid(in_valid_p),
    .in_ready(rdy_w[1]), .txd(txd_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );
  uart_tx #(.D_W(8), .B_TICK(16), .STOP_TICKS(16), .PAR_EN(1), .PAR_ODD(1)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .in_data(in_data_p), .in_valid(in_valid_p),
    .in_ready(rdy_w[2]), .txd(txd_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
  );

  initial forever #5 clk = ~clk;

  // Tick pulse every div clocks, changed on the falling edge.
  initial forever begin
    @(negedge clk);
    tick_c = (tick_c + 1 >= div) ? 0 : tick_c + 1;
    tick   = (tick_c == 0);
  end

  always @(posedge clk) if (tick) tick_total <= tick_total + 1;

  // Frame model: a frame is "active" for flen ticks; the line level follows from k.
  typedef struct {
    bit         active;
    int         k;
    logic [7:0] word;
    bit         full;
    logic [7:0] hold;
    bit         done;
  } ms_t;

  ms_t m0, m1, m2;

  function automatic ms_t ms_rst();
    ms_t s;
    s.active = 0; s.k = 0; s.word = '0; s.full = 0; s.hold = '0; s.done = 0;
    return s;
  endfunction

  function automatic ms_t step(ms_t s, bit v, logic [7:0] d, bit tk, int flen);
    ms_t n = s;
    n.done = 0;
    if (s.active) begin
      if (tk) begin
        n.k = s.k + 1;
        if (n.k == flen) begin
          n.active = 0;
          n.done   = 1;
        end
      end
    end else if (s.full) begin
      n.active = 1;
      n.k      = 0;
      n.word   = s.hold;
      n.full   = 0;
    end
    if (v && !s.full) begin
      n.hold = d;
      n.full = 1;
    end
    return n;
  endfunction

  function automatic logic exp_txd(ms_t s, bit pe, bit po);
    int b;
    if (!s.active) return 1'b1;
    b = s.k / 16;
    if (b == 0) return 1'b0;
    if (b <= 8) return s.word[b-1];
    if (pe && b == 9) return (^s.word) ^ po;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0 <= ms_rst();
      m1 <= ms_rst();
      m2 <= ms_rst();
    end else begin
      m0 <= step(m0, in_valid0, in_data0, tick, 160);
      m1 <= step(m1, in_valid_p, in_data_p, tick, 176);
      m2 <= step(m2, in_valid_p, in_data_p, tick, 176);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  task automatic cmp(input int i, input ms_t s, input bit pe, input bit po);
    check($sformatf("txd%0d", i), 32'(txd_w[i]), 32'(exp_txd(s, pe, po)));
    check($sformatf("in_ready%0d", i), 32'(rdy_w[i]), 32'(!s.full));
    check($sformatf("tx_busy%0d", i), 32'(busy_w[i]), 32'(s.active | s.full));
    check($sformatf("tx_done%0d", i), 32'(done_w[i]), 32'(s.done));
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp(0, m0, 1'b0, 1'b0);
      cmp(1, m1, 1'b1, 1'b0);
      cmp(2, m2, 1'b1, 1'b1);
    end
  end

  // Loopback receiver on dut0: mid-bit sampling after each falling start edge.
  initial forever begin
    logic [7:0] w;
    @(negedge clk);
    if (rst && txd_w[0] === 1'b0) begin
      repeat (bit_clks / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (bit_clks) @(negedge clk);
        w[i] = txd_w[0];
      end
      repeat (bit_clks) @(negedge clk);
      if (dec_en && txd_w[0] === 1'b1) rx_q.push_back(w);
    end
  end

  task automatic push0(input logic [7:0] d);
    int n = 0;
    in_data0  = d;
    in_valid0 = 1'b1;
    while (rdy_w[0] !== 1'b1 && n < 8000) begin @(negedge clk); n++; end
    if (n >= 8000) fail("push0");
    @(negedge clk);
    in_valid0 = 1'b0;
  endtask

  task automatic push_p(input logic [7:0] d);
    int n = 0;
    in_data_p  = d;
    in_valid_p = 1'b1;
    while (rdy_w[1] !== 1'b1 && n < 8000) begin @(negedge clk); n++; end
    if (n >= 8000) fail("push_p");
    @(negedge clk);
    in_valid_p = 1'b0;
  endtask

  // Samples each bit near its centre and counts ticks from frame load to tx_done.
  task automatic frame_check(input int i, input string nm, input logic [11:0] pat,
                             input int nbits, input int flen);
    int n = 0;
    int t0;
    logic [11:0] cap = '0;
    while (txd_w[i] !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
    if (n >= 4000) begin fail({nm, "_start"}); return; end
    t0 = tick_total;
    for (int j = 0; j < nbits; j++) begin
      repeat ((j == 0) ? bit_clks / 2 : bit_clks) @(negedge clk);
      cap[j] = txd_w[i];
    end
    check({nm, "_bits"}, 32'(cap), 32'(pat));
    n = 0;
    while (done_w[i] !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    if (n >= 4000) fail({nm, "_done"});
    else check({nm, "_ticks"}, tick_total - t0, flen);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    // 1: reset with in_valid held high
    in_valid0 = 1'b1;
    in_data0  = 8'hFF;
    #2 rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd_w[0]), 1);
    check("rst_ready", 32'(rdy_w[0]), 1);
    check("rst_busy", 32'(busy_w[0]), 0);
    check("rst_done", 32'(done_w[0]), 0);
    in_valid0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_nothing_ready", 32'(rdy_w[0]), 1);
    check("rst_nothing_busy", 32'(busy_w[0]), 0);

    // 2: 0xA5 -> 0,1,0,1,0,0,1,0,1,1 and 160 ticks
    push0(8'hA5);
    frame_check(0, "a5", 12'h34A, 10, 160);

    // 3: back-to-back, next start bit one clock after tx_done
    push0(8'h55);
    push0(8'h0F);
    n = 0;
    while (done_w[0] !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    if (n >= 4000) fail("b2b_done");
    check("b2b_gap_idle", 32'(txd_w[0]), 1);
    @(negedge clk);
    check("b2b_next_start", 32'(txd_w[0]), 0);

    // 4: three words queued
    push0(8'h11);
    push0(8'h22);
    check("q3_ready_low", 32'(rdy_w[0]), 0);
    push0(8'h33);
    n = 0;
    while (busy_w[0] !== 1'b0 && n < 8000) begin @(negedge clk); n++; end
    if (n >= 8000) fail("q3_idle");
    check("rx_count", rx_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("rx_word%0d", i), (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF, 32'(exp_rx[i]));

    // 5: parity on 0x07 (even -> 1, odd -> 0), 176 ticks
    push_p(8'h07);
    fork
      frame_check(1, "par_even", 12'h60E, 11, 176);
      frame_check(2, "par_odd", 12'h40E, 11, 176);
    join

    // 6: reset during data bit 3
    dec_en = 1'b0;
    push0(8'h5A);
    n = 0;
    while (txd_w[0] !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
    if (n >= 4000) fail("abort_start");
    repeat (32 + 4 * 64) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_txd", 32'(txd_w[0]), 1);
    check("abort_done", 32'(done_w[0]), 0);
    check("abort_busy", 32'(busy_w[0]), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(rdy_w[0]), 1);
    push0(8'h3C);
    frame_check(0, "after_abort", 12'h278, 10, 160);

    // 7: tick every clock
    div = 1;
    bit_clks = 16;
    repeat (4) @(negedge clk);
    push0(8'h81);
    frame_check(0, "fast", 12'h302, 10, 160);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
